// File: rtl/boot_loader.sv
// Stream boot loader: receives a start address, length and data, writes the data and the
// reset vector into memory, then releases the cpu. Optional checksum via LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_read_write,
  output logic        cpu_rst,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_write,
  output logic        mem_read_write,
  output logic        loading,
  output logic        error
);

  typedef enum logic [3:0] {
    HDR_AL, HDR_AH, LEN_L, LEN_H, DATA, VEC_L, VEC_H, RUN, ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  localparam logic [15:0] VECTOR_ADDR_HI = VECTOR_ADDR + 16'd1;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t DATA_DONE = CHK;
`else
  localparam state_t DATA_DONE = VEC_L;
`endif

  state_t      state;
  logic [15:0] start_addr;
  logic [15:0] count;
  logic [15:0] ptr;
  logic        xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      HDR_AL, HDR_AH, LEN_L, LEN_H, DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                                rx_ready = 1'b1;
`endif
      default:                            rx_ready = 1'b0;
    endcase
  end

  assign xfer    = rx_valid & rx_ready;
  assign loading = (state != RUN);

  // Data writes are zero-latency, so the memory bus is decoded straight from state and rx.
  always_comb begin
    mem_address    = 16'h0000;
    mem_data_write = 8'h00;
    mem_read_write = 1'b1;
    case (state)
      DATA: begin
        mem_address = ptr;
        if (rx_valid) begin
          mem_data_write = rx_data;
          mem_read_write = 1'b0;
        end
      end
      VEC_L: begin
        mem_address    = VECTOR_ADDR;
        mem_data_write = start_addr[7:0];
        mem_read_write = 1'b0;
      end
      VEC_H: begin
        mem_address    = VECTOR_ADDR_HI;
        mem_data_write = start_addr[15:8];
        mem_read_write = 1'b0;
      end
      RUN: begin
        mem_address    = cpu_address;
        mem_data_write = cpu_data_write;
        mem_read_write = cpu_read_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HDR_AL;
      start_addr <= 16'h0000;
      count      <= 16'h0000;
      ptr        <= 16'h0000;
      cpu_rst    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= 8'h00;
      error_q    <= 1'b0;
`endif
    end else begin
      case (state)
        HDR_AL: if (xfer) begin
          start_addr[7:0] <= rx_data;
          state           <= HDR_AH;
        end
        HDR_AH: if (xfer) begin
          start_addr[15:8] <= rx_data;
          ptr              <= {rx_data, start_addr[7:0]};
          state            <= LEN_L;
        end
        LEN_L: if (xfer) begin
          count[7:0] <= rx_data;
          state      <= LEN_H;
        end
        LEN_H: if (xfer) begin
          count[15:8] <= rx_data;
          state       <= ({rx_data, count[7:0]} != 16'h0000) ? DATA : DATA_DONE;
        end
        DATA: if (xfer) begin
          ptr   <= ptr + 16'd1;
          count <= count - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum   <= sum + rx_data;
`endif
          if (count == 16'd1) state <= DATA_DONE;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (xfer) begin
          if (rx_data == sum) begin
            state <= VEC_L;
          end else begin
            state   <= ERROR;
            error_q <= 1'b1;
          end
        end
`endif
        VEC_L: state <= VEC_H;
        VEC_H: begin
          state   <= RUN;
          cpu_rst <= 1'b1;
        end
        RUN:     ;
        ERROR:   ;
        default: state <= HDR_AL;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: expected memory writes go into a scoreboard queue when a stream is
// driven and are popped by a negedge monitor whenever the loader writes memory.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] cpu_address = 16'h0000;
  logic [7:0]  cpu_data_write = 8'h00;
  logic        cpu_read_write = 1'b1;
  logic        cpu_rst;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_write;
  logic        mem_read_write;
  logic        loading;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  data_buf [8];

  always #5 clk = ~clk;

  boot_loader #(.VECTOR_ADDR(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_address(cpu_address), .cpu_data_write(cpu_data_write), .cpu_read_write(cpu_read_write),
    .cpu_rst(cpu_rst), .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_read_write(mem_read_write), .loading(loading), .error(error)
  );

  // Scoreboard monitor: every loader-owned write must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (rst && loading && mem_read_write === 1'b0) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected: got %h@%h, none expected", mem_data_write, mem_address);
      end else begin
        e = exp_q.pop_front();
        if ({mem_address, mem_data_write} !== e) begin
          failures++;
          $display("FAIL mem_write: got %h@%h, expected %h@%h",
                   mem_data_write, mem_address, e[7:0], e[23:8]);
        end
      end
    end
  end

  // Entered and left just after a posedge; waits (bounded) until the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (rx_ready) acc = 1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_byte timeout: byte %h not accepted, rx_ready=%b", b, rx_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drives a full stream from data_buf and checks the vector writes and cpu release timing.
  task automatic load_stream(input logic [15:0] start, input int len, input int gap);
    logic [7:0]  sum = 8'h00;
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = start + 16'(i);
      exp_q.push_back({a, data_buf[i]});
      sum = sum + data_buf[i];
    end
    exp_q.push_back({16'hFFFC, start[7:0]});
    exp_q.push_back({16'hFFFD, start[15:8]});
    send_byte(start[7:0], 0);
    send_byte(start[15:8], 0);
    send_byte(8'(len), 0);
    send_byte(8'(len >> 8), 0);
    for (int i = 0; i < len; i++) send_byte(data_buf[i], (i > 0) ? gap : 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum, 0);
`endif
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL vec_l_state: cpu_rst=%b loading=%b, expected 0 1", cpu_rst, loading);
    end
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL vec_h_cpu_rst: got %b, expected 0", cpu_rst);
    end
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || loading !== 1'b0 || rx_ready !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL run_state: cpu_rst=%b loading=%b rx_ready=%b error=%b, expected 1 0 0 0",
               cpu_rst, loading, rx_ready, error);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL writes_pending: %0d expected writes never seen, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0 || loading !== 1'b1 || rx_ready !== 1'b1 || error !== 1'b0 ||
        mem_read_write !== 1'b1 || mem_address !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: cpu_rst=%b loading=%b rx_ready=%b error=%b rw=%b addr=%h, expected 0 1 1 0 1 0000",
               cpu_rst, loading, rx_ready, error, mem_read_write, mem_address);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_reset();
    data_buf[0] = 8'hA9; data_buf[1] = 8'h05; data_buf[2] = 8'hEA;
    load_stream(16'h0200, 3, 0);
  endtask

  task automatic test_zero_len();
    do_reset();
    load_stream(16'h1234, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    data_buf[0] = 8'h11; data_buf[1] = 8'h22;
    load_stream(16'hFFFF, 2, 0);
  endtask

  task automatic test_valid_gaps();
    do_reset();
    for (int i = 0; i < 5; i++) data_buf[i] = 8'(8'h40 + i * 3);
    load_stream(16'h0500, 5, 1);
  endtask

  task automatic test_run_passthrough();
    cpu_address = 16'h1234; cpu_data_write = 8'h5A; cpu_read_write = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_address !== 16'h1234 || mem_data_write !== 8'h5A || mem_read_write !== 1'b0 ||
        loading !== 1'b0 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL run_passthrough: addr=%h data=%h rw=%b loading=%b cpu_rst=%b, expected 1234 5a 0 0 1",
               mem_address, mem_data_write, mem_read_write, loading, cpu_rst);
    end
    cpu_address = 16'hBEEF; cpu_read_write = 1'b1;
    #1;
    checks++;
    if (mem_address !== 16'hBEEF || mem_read_write !== 1'b1) begin
      failures++;
      $display("FAIL run_passthrough2: addr=%h rw=%b, expected beef 1", mem_address, mem_read_write);
    end
    rx_valid = 1'b0;
    cpu_address = 16'h0000; cpu_data_write = 8'h00;
  endtask

  task automatic test_reset_midload();
    do_reset();
    exp_q.push_back({16'h0300, 8'h77});
    exp_q.push_back({16'h0301, 8'h88});
    send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_rst !== 1'b0 || rx_ready !== 1'b1 || loading !== 1'b1 || mem_read_write !== 1'b1) begin
      failures++;
      $display("FAIL midload_reset: cpu_rst=%b rx_ready=%b loading=%b rw=%b, expected 0 1 1 1",
               cpu_rst, rx_ready, loading, mem_read_write);
    end
    rst = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midload_writes: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    data_buf[0] = 8'hC1; data_buf[1] = 8'hC2; data_buf[2] = 8'hC3;
    load_stream(16'h0600, 3, 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    data_buf[0] = 8'h01; data_buf[1] = 8'h02;
    load_stream(16'h0400, 2, 0);
    do_reset();
    exp_q.push_back({16'h0400, 8'h01});
    exp_q.push_back({16'h0401, 8'h02});
    send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (error !== 1'b1 || cpu_rst !== 1'b0 || rx_ready !== 1'b0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL bad_checksum: error=%b cpu_rst=%b rx_ready=%b loading=%b, expected 1 0 0 1",
               error, cpu_rst, rx_ready, loading);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_checksum_writes: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_run_passthrough();
    test_zero_len();
    test_wrap();
    test_valid_gaps();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter VECTOR_ADDR, default 16'hFFFC, is the address of the reset-vector low byte; the high byte goes to VECTOR_ADDR+1.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 rx_data  input  8  incoming load-stream byte.
REQ-005 rx_valid  input  1  rx_data is valid this cycle.
REQ-006 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-007 cpu_address  input  16  cpu bus address.
REQ-008 cpu_data_write  input  8  cpu write data.
REQ-009 cpu_read_write  input  1  cpu direction; 1 = read, 0 = write.
REQ-010 cpu_rst  output  1  active-low reset to the cpu; low holds the cpu in reset.
REQ-011 mem_address  output  16  memory address.
REQ-012 mem_data_write  output  8  memory write data.
REQ-013 mem_read_write  output  1  memory direction; 1 = read, 0 = write.
REQ-014 loading  output  1  high whenever the loader owns the memory bus.
REQ-015 error  output  1  checksum failure flag (see Configuration).

Function
REQ-016 The stream format is, in order: start address low byte, start address high byte, length low byte, length high byte, then exactly length data bytes.
REQ-017 The FSM states are HDR_AL, HDR_AH, LEN_L, LEN_H, DATA, VEC_L, VEC_H, RUN, ERROR; each header state advances on a transfer only.
REQ-018 rx_ready is 1 in HDR_AL, HDR_AH, LEN_L, LEN_H and DATA; it is 0 in VEC_L, VEC_H, RUN and ERROR.
REQ-019 LEN_H advances to DATA if the 16-bit length is nonzero, and to VEC_L if it is zero.
REQ-020 In DATA, a transfer drives mem_read_write=0, mem_data_write=rx_data and mem_address=load pointer in the same cycle (zero latency).
REQ-021 In DATA, the load pointer increments and the remaining count decrements on each transfer.
REQ-022 In DATA with no transfer, mem_read_write=1.
REQ-023 The load pointer wraps from 16'hFFFF to 16'h0000 without error.
REQ-024 DATA advances to VEC_L on the transfer that takes the remaining count from 1 to 0.
REQ-025 VEC_L lasts exactly one cycle and writes the start-address low byte to VECTOR_ADDR.
REQ-026 VEC_H lasts exactly one cycle and writes the start-address high byte to VECTOR_ADDR+1.
REQ-027 VEC_H then enters RUN.
REQ-028 cpu_rst is a registered output: it goes high on the first clock edge in RUN, one cycle after VEC_H.
REQ-029 cpu_rst is low in every other state.
REQ-030 In RUN, loading=0 and the mem_* outputs equal the cpu_* inputs combinationally.
REQ-031 In RUN, rx_valid is ignored; the FSM leaves RUN only on reset.
REQ-032 In all non-RUN states, loading=1 and the cpu_* inputs are ignored.
REQ-033 In header states and ERROR, mem_read_write=1 and mem_address=16'h0000.

Reset
REQ-034 While rst=0 at a clock edge, the next state is: HDR_AL, cpu_rst=0, loading=1, rx_ready=1, error=0, load pointer=0, count=0, and mem_read_write=1.
REQ-035 Reset asserted mid-load or in RUN aborts the load immediately and returns to HDR_AL with the cpu held in reset.
REQ-036 Memory contents already written are left as-is.

Configuration
REQ-037 With LOADER_CHECKSUM_EN defined, one checksum byte follows the data; it is received in an extra state CHK with rx_ready=1.
REQ-038 The checksum byte is checked against the 8-bit modulo-256 sum of all data bytes.
REQ-039 On match, CHK advances to VEC_L.
REQ-040 On mismatch, CHK enters ERROR, sets error=1 and keeps cpu_rst=0 until reset.
REQ-041 With zero length, the expected checksum is 8'h00.
REQ-042 Without LOADER_CHECKSUM_EN, there is no CHK state, error is tied to 0, and DATA/LEN_H go directly to VEC_L.

Verification
REQ-043 Stream 00 02 03 00 A9 05 EA -> writes A9@0200, 05@0201, EA@0202; then 00@FFFC, 02@FFFD; cpu_rst rises one cycle after the FFFD write.
REQ-044 Length 0000 (stream 34 12 00 00) -> no data writes; 34@FFFC, 12@FFFD; cpu_rst=1 two cycles after the fourth byte.
REQ-045 Start FFFF, length 2, data 11 22 -> 11@FFFF, 22@0000.
REQ-046 rx_valid toggled every other cycle during DATA -> writes occur only on valid cycles, with no gaps in addresses.
REQ-047 rst=0 asserted after 2 of 3 data bytes, then a fresh stream -> cpu_rst stays 0 throughout; the fresh stream loads correctly from HDR_AL.
REQ-048 With LOADER_CHECKSUM_EN defined, data 01 02 with checksum 03 -> RUN; the same data with checksum 04 -> error=1, cpu_rst=0, rx_ready=0, and no vector writes.
